// File: rtl/l2_cacheline_adaptor.sv
// Bridges the L2 single-beat line port to a 4-beat 64-bit memory burst bus.
// Reads assemble four beats into one line; writebacks split one line into four beats.
module l2_cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int BEATS   = LINE_W / BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_address,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int LG_BW  = $clog2(BURST_W);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_DONE} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, beat_nxt;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   rline_q, rline_d;
  logic [BURST_W-1:0]  wdata_q, wdata_d;
  logic                resp_q, resp_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;

  assign beat_nxt = beat_q + 1'b1;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    wdata_d = wdata_q;
    resp_d  = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        // Writeback is served before the fill so the victim line reaches memory first.
        if (line_write) begin
          addr_d  = {line_address[31:OFF_W], {OFF_W{1'b0}}};
          wline_d = line_wdata;
          wdata_d = line_wdata[BURST_W-1:0];
          beat_d  = '0;
          wr_d    = 1'b1;
          state_d = WR;
        end else if (line_read) begin
          addr_d  = {line_address[31:OFF_W], {OFF_W{1'b0}}};
          beat_d  = '0;
          rd_d    = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        if (burst_resp) begin
          rline_d[{beat_q, {LG_BW{1'b0}}} +: BURST_W] = burst_rdata;
          beat_d = beat_nxt;
          if (beat_q == LAST) begin
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = RD_DONE;
          end
        end
      end
      WR: begin
        if (burst_resp) begin
          beat_d = beat_nxt;
          if (beat_q == LAST) begin
            wr_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = WR_DONE;
          end else begin
            wdata_d = wline_q[{beat_nxt, {LG_BW{1'b0}}} +: BURST_W];
          end
        end
      end
      RD_DONE, WR_DONE: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign line_rdata    = rline_q;
  assign line_resp     = resp_q;
  assign burst_read    = rd_q;
  assign burst_write   = wr_q;
  assign burst_address = addr_q;
  assign burst_wdata   = wdata_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Scoreboard bench: stimulus queues expected beats/lines, a negedge monitor pops and compares.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         line_read = 1'b0, line_write = 1'b0;
  logic [31:0]  line_address = '0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp, burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;

  l2_cacheline_adaptor dut (
    .clk(clk), .rst_n(rst_n),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [31:0] addr; logic [63:0] data; } beat_t;
  typedef struct { logic wr; logic [255:0] line; } line_t;
  beat_t beatq[$];
  line_t lineq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted beat and every line_resp is matched against the queues.
  always @(negedge clk) begin
    if (burst_read && burst_write) chk("rd_wr_exclusive", 1, 0);
    if ((burst_read || burst_write) && burst_resp && rst_n) begin
      if (beatq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        beat_t b;
        b = beatq.pop_front();
        chk("beat_kind", burst_write, b.wr);
        chk("burst_address", burst_address, b.addr);
        if (b.wr) chk("burst_wdata", burst_wdata, b.data);
      end
    end
    if (line_resp) begin
      if (lineq.size() == 0) chk("unexpected_line_resp", 1, 0);
      else begin
        line_t l;
        l = lineq.pop_front();
        chk("resp_after_all_beats", beatq.size(), 0);
        chk("resp_kind_no_burst", {burst_read, burst_write}, 0);
        if (!l.wr) chk("line_rdata", line_rdata, l.line);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_sig(input int which, input string nm);
    int n = 0;
    logic s;
    s = (which == 0) ? burst_read : (which == 1) ? burst_write : line_resp;
    while (!s && n < 50) begin
      tick(); n++;
      s = (which == 0) ? burst_read : (which == 1) ? burst_write : line_resp;
    end
    if (!s) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got 0 expected 1", nm);
    end
  endtask

  task automatic serve_read(input logic [31:0] addr, input logic [255:0] line,
                            input int gap, input bit move_addr);
    logic [31:0] a;
    a = {addr[31:5], 5'b0};
    for (int i = 0; i < 4; i++) beatq.push_back('{1'b0, a, 64'h0});
    lineq.push_back('{1'b0, line});
    wait_sig(0, "burst_read");
    if (move_addr) line_address = 32'hFFFF_FFE0;
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b0;
      repeat (gap) tick();
      burst_resp = 1'b1;
      burst_rdata = line[64*i +: 64];
      tick();
    end
    burst_resp = 1'b0;
    burst_rdata = '0;
    wait_sig(2, "rd_line_resp");
    line_read = 1'b0;
    tick();
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [255:0] line, input int gap);
    logic [31:0] a;
    a = {addr[31:5], 5'b0};
    for (int i = 0; i < 4; i++) beatq.push_back('{1'b1, a, line[64*i +: 64]});
    lineq.push_back('{1'b1, line});
    wait_sig(1, "burst_write");
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b0;
      repeat (gap) tick();
      burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    wait_sig(2, "wr_line_resp");
    line_write = 1'b0;
    tick();
  endtask

  localparam logic [255:0] RLINE = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
  localparam logic [255:0] WLINE = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
  localparam logic [255:0] RLINE2 = 256'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A_C3C3C3C3C3C3C3C3_3C3C3C3C3C3C3C3C;

  initial begin
    #1;
    chk("rst_outputs", {line_resp, burst_read, burst_write, burst_address, burst_wdata}, 0);
    chk("rst_line_rdata", line_rdata, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back read fill at an unaligned address.
    line_read = 1'b1; line_address = 32'h0000_1234;
    serve_read(32'h0000_1234, RLINE, 0, 1'b0);
    chk("rdata_held", line_rdata, RLINE);

    // Writeback split into ascending beats.
    line_write = 1'b1; line_address = 32'h0000_8040; line_wdata = WLINE;
    serve_write(32'h0000_8040, WLINE, 0);

    // Stalled read: a beat every third cycle, address moved mid-burst.
    line_read = 1'b1; line_address = 32'h0001_0077;
    serve_read(32'h0001_0077, RLINE2, 2, 1'b1);

    // Spurious burst_resp in IDLE: no capture, no request raised.
    burst_resp = 1'b1; burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) tick();
    burst_resp = 1'b0; burst_rdata = '0;
    chk("idle_no_capture", line_rdata, RLINE2);
    chk("idle_no_request", {burst_read, burst_write}, 0);

    // Simultaneous read and write: write goes first, then the still-held read.
    line_read = 1'b1; line_write = 1'b1;
    line_address = 32'h0000_2000; line_wdata = ~WLINE;
    serve_write(32'h0000_2000, ~WLINE, 1);
    serve_read(32'h0000_2000, RLINE, 0, 1'b0);

    // Reset after two read beats: everything clears, no response.
    line_read = 1'b1; line_address = 32'h0000_4000;
    for (int i = 0; i < 2; i++) beatq.push_back('{1'b0, 32'h0000_4000, 64'h0});
    wait_sig(0, "burst_read_rst");
    for (int i = 0; i < 2; i++) begin
      burst_resp = 1'b1; burst_rdata = 64'hBAD0_0000_0000_0000 | 64'(i);
      tick();
    end
    burst_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {line_resp, burst_read, burst_write, burst_address, burst_wdata}, 0);
    chk("midrst_line_rdata", line_rdata, 0);
    line_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    line_read = 1'b1; line_address = 32'h0000_4010;
    serve_read(32'h0000_4010, RLINE2, 0, 1'b0);

    repeat (3) tick();
    chk("beatq_drained", beatq.size(), 0);
    chk("lineq_drained", lineq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
